lcd_bus_driver: RTL
===================

# lcd_bus_driver

Downstream consumer of the memory-mapped LCD registers in the data RAM: byte 0 data, byte 4 control, byte 8 enable. Turns a software rising edge on the enable register into one correctly timed HD44780 write cycle (setup, E pulse, hold), then waits out the controller's execution time. Buffers one command arriving while busy and flags overruns. Drives the physical LCD pins.

## Interface
- `SETUP_CYCLES`, default 2: cycles RS/DB are stable before E rises (tAS).
- `PULSE_CYCLES`, default 12: cycles E is held high (PW_EH).
- `HOLD_CYCLES`, default 2: cycles RS/DB are held after E falls (tH).
- `EXEC_CYCLES`, default 1850: post-write wait for normal instructions and data (37 us at 50 MHz).
- `LONG_EXEC_CYCLES`, default 76000: post-write wait for clear/home (1.52 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lcd_data`  in  8  data/instruction byte from RAM byte 0.
- `lcd_ctrl`  in  2  bit0 = RS (1 data, 0 instruction); bit1 ignored (write-only driver).
- `lcd_enable`  in  1  LSB of RAM byte 8; a rising edge requests a write.
- `lcd_db`  out  8  LCD data bus.
- `lcd_rs`  out  1  LCD register select.
- `lcd_rw`  out  1  always 0.
- `lcd_e`  out  1  LCD enable strobe.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a command's execution wait ends.
- `overrun`  out  1  sticky; a request was dropped.

## Operation
- Edge detect: register `en_q`, which resets to 1 so a level already high at reset release does not trigger. Request = `lcd_enable & ~en_q`.
- Each request samples `{lcd_ctrl[0], lcd_data}` in the same cycle as the edge.
- `long` = (RS == 0) && (data == 8'h01 || data[7:1] == 7'b0000001).
- FSM states: IDLE, SETUP, PULSE, HOLD, EXEC.
  - IDLE → SETUP on request. The sampled command loads `lcd_rs`/`lcd_db`.
  - SETUP → PULSE after SETUP_CYCLES. `lcd_e` is 1 throughout PULSE.
  - PULSE → HOLD after PULSE_CYCLES. `lcd_e` returns to 0.
  - HOLD → EXEC after HOLD_CYCLES. EXEC lasts LONG_EXEC_CYCLES if `long`, else EXEC_CYCLES.
  - At EXEC end, `done` pulses for one cycle:
    - pending buffer valid → go directly to SETUP with the pending command and clear pending.
    - pending buffer empty → go to IDLE.
- Pending buffer (one entry):
  - A request in any non-IDLE state fills it if empty.
  - A request when it is already full is dropped and sets `overrun`.
  - A request in the same cycle as EXEC→SETUP consumption is accepted into the just-freed slot.
- `lcd_db`/`lcd_rs` hold their last values in IDLE.
- One down-counter sized `$clog2(LONG_EXEC_CYCLES+1)` bits, reloaded with (N−1) on each state entry. A state exits on the cycle the counter reads 0.
- Reset mid-operation: everything clears immediately, `lcd_e` drops asynchronously, and the pending command is lost.

## Timing
- Reset values: `lcd_db`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_e`=0, `busy`=0, `done`=0, `overrun`=0, state IDLE, pending empty, `en_q`=1.
- All outputs are registered.
- Edge seen at posedge t → `busy`, `lcd_rs`, `lcd_db` valid from t+1.
- `lcd_e` high for exactly PULSE_CYCLES cycles, starting at t+1+SETUP_CYCLES.
- `done` high at the single cycle t+1+SETUP+PULSE+HOLD+EXEC_n−1, i.e. the last EXEC cycle. `busy` falls the next cycle if nothing is pending.
- Back-to-back pending command: its SETUP begins the cycle after `done`, with no IDLE cycle in between.
- A held-high `lcd_enable` yields exactly one request.

## Structure
- Package `lcd_pkg`:
  - state enum (IDLE=0, SETUP=1, PULSE=2, HOLD=3, EXEC=4, 3-bit);
  - `LCD_CMD_CLEAR=8'h01`, `LCD_CMD_HOME=8'h02`;
  - `LCD_CTRL_RS_BIT=0`.
- Sub-module `lcd_delay_counter`: parameterised width; load value, load strobe, `zero` flag. It is the one natural split.

## Test plan
Bench parameters: SETUP=2, PULSE=3, HOLD=2, EXEC=5, LONG=20.

- Reset, then enable low → all outputs 0, `busy`=0. Enable held 1 through reset release → no write.
- Data 8'h41, RS=1, enable 0→1 at cycle t → `lcd_db`=8'h41 and `lcd_rs`=1 from t+1; `lcd_e`=1 for cycles t+3..t+5; `done` at t+12; `busy` low at t+13.
- Instruction 8'h01, RS=0 → EXEC lasts 20 cycles, `done` at t+27. Instruction 8'h38 → `done` at t+12.
- Second edge (8'h42) during EXEC of the first → second SETUP starts the cycle after the first `done`. One `done` per command; `overrun` stays 0.
- Three edges in one busy period → third is dropped and `overrun`=1 until reset. Only two `lcd_e` pulses occur.
- `rst_n` asserted while `lcd_e`=1 → `lcd_e` drops immediately, `busy`=0, and no `done` follows.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only bus driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
  localparam int         LCD_CTRL_RS_BIT = 0;

  // Clear display and return home (0x02/0x03) need the long execution wait.
  function automatic logic lcd_is_long(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data[7:1] == LCD_CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that stops at zero; times every phase of the write cycle.
module lcd_delay_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - WIDTH'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// Turns a software enable edge into one timed HD44780 write plus execution wait,
// with a single-entry pending buffer for a command arriving while busy.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES     = 2,
  parameter int PULSE_CYCLES     = 12,
  parameter int HOLD_CYCLES      = 2,
  parameter int EXEC_CYCLES      = 1850,
  parameter int LONG_EXEC_CYCLES = 76000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] lcd_data,
  input  logic [1:0] lcd_ctrl,
  input  logic       lcd_enable,
  output logic [7:0] lcd_db,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int CW = $clog2(LONG_EXEC_CYCLES + 1);
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] EXEC_LOAD  = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LOAD  = CW'(LONG_EXEC_CYCLES - 1);

  lcd_state_e    state, next_state;
  logic          en_q, req;
  logic [8:0]    req_cmd;
  logic          pend_valid, pend_valid_nxt;
  logic [8:0]    pend_cmd, pend_cmd_nxt;
  logic          cur_long;
  logic          load;
  logic [CW-1:0] load_val, cnt;
  logic          cnt_zero, next_cnt_zero;
  logic          launch, req_used, overrun_set;
  logic [8:0]    launch_cmd;
  logic          ctrl_unused;

  assign ctrl_unused = lcd_ctrl[1];
  assign req         = lcd_enable & ~en_q;
  assign req_cmd     = {lcd_ctrl[LCD_CTRL_RS_BIT], lcd_data};
  assign lcd_rw      = 1'b0;

  lcd_delay_counter #(.WIDTH(CW)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // A request arriving on the final EXEC cycle with nothing pending is launched
  // directly, so it can never be parked in the buffer while the FSM goes idle.
  always_comb begin
    next_state     = state;
    load           = 1'b0;
    load_val       = '0;
    launch         = 1'b0;
    launch_cmd     = req_cmd;
    req_used       = 1'b0;
    pend_valid_nxt = pend_valid;
    pend_cmd_nxt   = pend_cmd;
    overrun_set    = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          launch   = 1'b1;
          req_used = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          next_state = PULSE;
          load       = 1'b1;
          load_val   = PULSE_LOAD;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          next_state = HOLD;
          load       = 1'b1;
          load_val   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          next_state = EXEC;
          load       = 1'b1;
          load_val   = cur_long ? LONG_LOAD : EXEC_LOAD;
        end
      end
      EXEC: begin
        if (cnt_zero) begin
          if (pend_valid) begin
            launch         = 1'b1;
            launch_cmd     = pend_cmd;
            pend_valid_nxt = 1'b0;
          end else if (req) begin
            launch   = 1'b1;
            req_used = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase

    if (launch) begin
      next_state = SETUP;
      load       = 1'b1;
      load_val   = SETUP_LOAD;
    end

    if (req && !req_used) begin
      if (!pend_valid_nxt) begin
        pend_valid_nxt = 1'b1;
        pend_cmd_nxt   = req_cmd;
      end else begin
        overrun_set = 1'b1;
      end
    end

    next_cnt_zero = load ? (load_val == '0) : (cnt <= CW'(1));
  end

  // Outputs are registered from the next-state view so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      en_q       <= 1'b1;
      pend_valid <= 1'b0;
      pend_cmd   <= '0;
      cur_long   <= 1'b0;
      lcd_db     <= '0;
      lcd_rs     <= 1'b0;
      lcd_e      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= next_state;
      en_q       <= lcd_enable;
      pend_valid <= pend_valid_nxt;
      pend_cmd   <= pend_cmd_nxt;
      if (launch) begin
        lcd_rs   <= launch_cmd[8];
        lcd_db   <= launch_cmd[7:0];
        cur_long <= lcd_is_long(launch_cmd[8], launch_cmd[7:0]);
      end
      lcd_e   <= (next_state == PULSE);
      busy    <= (next_state != IDLE);
      done    <= (next_state == EXEC) && next_cnt_zero;
      overrun <= overrun | overrun_set;
    end
  end

endmodule
